// File: rtl/core_pkg.sv
// Shared types for the core pipeline control.
// Hazard FSM states, next-PC selects and writeback encodings.
package core_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LD_STALL   = 3'd1,
        MEM_WAIT   = 3'd2,
        IMISS_WAIT = 3'd3,
        REDIRECT   = 3'd4
    } hz_state_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_INTR = 2'd2,
        PC_MRET = 2'd3
    } pc_sel_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // Redirect priority: interrupt over mret over branch over none.
    function automatic logic [1:0] redir_rank(input pc_sel_e s);
        logic [1:0] r;
        unique case (s)
            PC_INTR: r = 2'd3;
            PC_MRET: r = 2'd2;
            PC_BR:   r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination
// feeds rs1/rs2 of the instruction sitting in decode.
module hazard_detect
    import core_pkg::*;
(
    input  logic [31:0] inst_d_i,
    input  logic [4:0]  rsW_ex_i,
    input  logic        RegWEn_ex_i,
    input  logic [1:0]  WBSel_ex_i,
    output logic        load_use_o
);

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ex_load;
    logic       unused_inst;

    assign rs1 = inst_d_i[19:15];
    assign rs2 = inst_d_i[24:20];
    assign unused_inst = ^{inst_d_i[31:25], inst_d_i[14:0]};

    // x0 is never a real dependency, so it is excluded here.
    assign ex_load = RegWEn_ex_i
                   && (WBSel_ex_i == WB_MEM)
                   && (rsW_ex_i != 5'd0);

    assign load_use_o = ex_load
                      && ((rsW_ex_i == rs1) || (rsW_ex_i == rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Owns the hazard FSM, pending redirect, miss timeout and stall counter.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      inst_d_i,
    input  logic [4:0]       rsW_ex_i,
    input  logic             RegWEn_ex_i,
    input  logic [1:0]       WBSel_ex_i,
    input  logic             br_taken_ex_i,
    input  logic             dreq_ex_i,
    input  logic             dready_i,
    input  logic             ihit_i,
    input  logic             intr_flag_i,
    input  logic             is_mret_i,
    output logic             en_f_o,
    output logic             en_d_o,
    output logic             en_e_o,
    output logic             en_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       pc_sel_o,
    output logic [2:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(MISS_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST =
        (MISS_TIMEOUT > 0) ? TW'(MISS_TIMEOUT - 1) : '0;

    hz_state_e        state_q;
    hz_state_e        state_d;
    pc_sel_e          pend_q;
    pc_sel_e          pend_d;
    pc_sel_e          ev;
    pc_sel_e          redir_all;
    pc_sel_e          pc_sel;
    logic [TW-1:0]    tmo_q;
    logic [TW-1:0]    tmo_d;
    logic [CNT_W-1:0] stall_q;
    logic             load_use;
    logic             dmiss;
    logic             in_wait;

    hazard_detect u_detect (
        .inst_d_i    (inst_d_i),
        .rsW_ex_i    (rsW_ex_i),
        .RegWEn_ex_i (RegWEn_ex_i),
        .WBSel_ex_i  (WBSel_ex_i),
        .load_use_o  (load_use)
    );

    assign dmiss   = dreq_ex_i && !dready_i;
    assign in_wait = (state_q == MEM_WAIT) || (state_q == IMISS_WAIT);

    // Pick this cycle's redirect and merge it with any latched one.
    always_comb begin
        ev = PC_SEQ;
        if (intr_flag_i)        ev = PC_INTR;
        else if (is_mret_i)     ev = PC_MRET;
        else if (br_taken_ex_i) ev = PC_BR;
        redir_all = (redir_rank(ev) > redir_rank(pend_q)) ? ev : pend_q;
    end

    // Next state and stage controls; reset forces free-running outputs.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        en_f_o    = 1'b1;
        en_d_o    = 1'b1;
        en_e_o    = 1'b1;
        en_m_o    = 1'b1;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        pc_sel    = PC_SEQ;
        if (rst_ni) begin
            unique case (state_q)
                RUN, LD_STALL: begin
                    if (dmiss) begin
                        {en_f_o, en_d_o, en_e_o, en_m_o} = 4'b0000;
                        pend_d  = ev;
                        state_d = MEM_WAIT;
                    end else if (ev != PC_SEQ) begin
                        pc_sel    = ev;
                        flush_d_o = 1'b1;
                        flush_e_o = 1'b1;
                        state_d   = (ev == PC_BR) ? RUN : REDIRECT;
                    end else if (load_use && (state_q == RUN)) begin
                        en_f_o    = 1'b0;
                        en_d_o    = 1'b0;
                        flush_e_o = 1'b1;
                        state_d   = LD_STALL;
                    end else if (!ihit_i) begin
                        en_f_o    = 1'b0;
                        flush_d_o = 1'b1;
                        state_d   = IMISS_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (dready_i) begin
                        pc_sel  = redir_all;
                        pend_d  = PC_SEQ;
                        if (redir_all != PC_SEQ) begin
                            flush_d_o = 1'b1;
                            flush_e_o = 1'b1;
                        end
                        if ((redir_all == PC_INTR) || (redir_all == PC_MRET))
                            state_d = REDIRECT;
                        else
                            state_d = RUN;
                    end else begin
                        {en_f_o, en_d_o, en_e_o, en_m_o} = 4'b0000;
                        pend_d = redir_all;
                    end
                end
                IMISS_WAIT: begin
                    if (dmiss) begin
                        {en_f_o, en_d_o, en_e_o, en_m_o} = 4'b0000;
                        pend_d  = ev;
                        state_d = MEM_WAIT;
                    end else if (ev != PC_SEQ) begin
                        pc_sel    = ev;
                        flush_d_o = 1'b1;
                        flush_e_o = 1'b1;
                        state_d   = (ev == PC_BR) ? RUN : REDIRECT;
                    end else if (ihit_i) begin
                        state_d = RUN;
                    end else begin
                        en_f_o    = 1'b0;
                        flush_d_o = 1'b1;
                    end
                end
                REDIRECT: begin
                    flush_d_o = 1'b1;
                    flush_e_o = 1'b1;
                    state_d   = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Miss-wait counter restarts on every state change and saturates.
    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q)
            tmo_d = '0;
        else if (in_wait && (tmo_q != TMO_MAX))
            tmo_d = tmo_q + 1'b1;
    end

    // FSM state, latched redirect and timeout counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pend_q  <= PC_SEQ;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
        end
    end

    // Count every cycle the fetch stage is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_q <= '0;
        else if (!en_f_o)
            stall_q <= stall_q + 1'b1;
    end

    assign timeout_o   = (MISS_TIMEOUT != 0) && rst_ni && in_wait
                       && (tmo_q == TMO_LAST);
    assign pc_sel_o    = pc_sel;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expectations,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import core_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] inst_d_i;
    logic [4:0]  rsW_ex_i;
    logic        RegWEn_ex_i;
    logic [1:0]  WBSel_ex_i;
    logic        br_taken_ex_i;
    logic        dreq_ex_i;
    logic        dready_i;
    logic        ihit_i;
    logic        intr_flag_i;
    logic        is_mret_i;
    logic        en_f_o, en_d_o, en_e_o, en_m_o;
    logic        flush_d_o, flush_e_o;
    logic [1:0]  pc_sel_o;
    logic [2:0]  state_o;
    logic        timeout_o;
    logic [31:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MISS_TIMEOUT(3), .CNT_W(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .inst_d_i      (inst_d_i),
        .rsW_ex_i      (rsW_ex_i),
        .RegWEn_ex_i   (RegWEn_ex_i),
        .WBSel_ex_i    (WBSel_ex_i),
        .br_taken_ex_i (br_taken_ex_i),
        .dreq_ex_i     (dreq_ex_i),
        .dready_i      (dready_i),
        .ihit_i        (ihit_i),
        .intr_flag_i   (intr_flag_i),
        .is_mret_i     (is_mret_i),
        .en_f_o        (en_f_o),
        .en_d_o        (en_d_o),
        .en_e_o        (en_e_o),
        .en_m_o        (en_m_o),
        .flush_d_o     (flush_d_o),
        .flush_e_o     (flush_e_o),
        .pc_sel_o      (pc_sel_o),
        .state_o       (state_o),
        .timeout_o     (timeout_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    typedef struct packed {
        logic [3:0]  en;
        logic [1:0]  fl;
        logic [1:0]  pc;
        logic [2:0]  st;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_cnt = 32'd0;
    localparam logic [3:0] F = 4'b1111;

    task automatic chk(input string n, input string f,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s.%s: got %0h want %0h", n, f, act, want);
    endtask

    // Monitor: every negedge with a pending expectation is a check point.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk(n, "en", {28'd0, en_f_o, en_d_o, en_e_o, en_m_o}, {28'd0, e.en});
            chk(n, "flush", {30'd0, flush_d_o, flush_e_o}, {30'd0, e.fl});
            chk(n, "pc_sel", {30'd0, pc_sel_o}, {30'd0, e.pc});
            chk(n, "state", {29'd0, state_o}, {29'd0, e.st});
            chk(n, "timeout", {31'd0, timeout_o}, {31'd0, e.to});
            chk(n, "stall_cnt", stall_cnt_o, e.cnt);
        end
    end

    task automatic idle();
        inst_d_i      = 32'h0000_0013;
        rsW_ex_i      = 5'd0;
        RegWEn_ex_i   = 1'b0;
        WBSel_ex_i    = WB_ALU;
        br_taken_ex_i = 1'b0;
        dreq_ex_i     = 1'b0;
        dready_i      = 1'b0;
        ihit_i        = 1'b1;
        intr_flag_i   = 1'b0;
        is_mret_i     = 1'b0;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd6, 7'b0110011};
    endfunction

    task automatic lw_in_ex(input logic [4:0] rd);
        rsW_ex_i    = rd;
        RegWEn_ex_i = 1'b1;
        WBSel_ex_i  = WB_MEM;
    endtask

    // Inputs are already set for this cycle; queue the expected outputs.
    task automatic tick(input string n, input logic [3:0] en,
                        input logic [1:0] fl, input pc_sel_e pc,
                        input hz_state_e st, input logic to);
        exp_t e;
        e.en  = en;
        e.fl  = fl;
        e.pc  = pc;
        e.st  = st;
        e.to  = to;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        name_q.push_back(n);
        if (!en[3]) exp_cnt++;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk_i);
        #1;
        tick("reset", F, 2'b00, PC_SEQ, RUN, 1'b0);
        rst_ni = 1'b1;
        tick("idle", F, 2'b00, PC_SEQ, RUN, 1'b0);

        inst_d_i = mk_r(5'd5, 5'd1);
        lw_in_ex(5'd5);
        tick("lu_rs1", 4'b0011, 2'b01, PC_SEQ, RUN, 1'b0);
        inst_d_i = mk_r(5'd5, 5'd1);
        tick("lu_hold", F, 2'b00, PC_SEQ, LD_STALL, 1'b0);
        tick("lu_back", F, 2'b00, PC_SEQ, RUN, 1'b0);
        inst_d_i = mk_r(5'd3, 5'd7);
        lw_in_ex(5'd7);
        tick("lu_rs2", 4'b0011, 2'b01, PC_SEQ, RUN, 1'b0);
        tick("lu_rs2_hold", F, 2'b00, PC_SEQ, LD_STALL, 1'b0);

        inst_d_i = mk_r(5'd0, 5'd2);
        lw_in_ex(5'd0);
        tick("lu_x0", F, 2'b00, PC_SEQ, RUN, 1'b0);
        tick("lu_x0_next", F, 2'b00, PC_SEQ, RUN, 1'b0);
        inst_d_i = mk_r(5'd5, 5'd1);
        rsW_ex_i = 5'd5;
        RegWEn_ex_i = 1'b1;
        tick("alu_dep", F, 2'b00, PC_SEQ, RUN, 1'b0);

        br_taken_ex_i = 1'b1;
        intr_flag_i = 1'b1;
        tick("br_intr", F, 2'b11, PC_INTR, RUN, 1'b0);
        tick("redirect", F, 2'b11, PC_SEQ, REDIRECT, 1'b0);
        tick("redir_done", F, 2'b00, PC_SEQ, RUN, 1'b0);
        is_mret_i = 1'b1;
        br_taken_ex_i = 1'b1;
        tick("mret", F, 2'b11, PC_MRET, RUN, 1'b0);
        tick("mret_redir", F, 2'b11, PC_SEQ, REDIRECT, 1'b0);
        br_taken_ex_i = 1'b1;
        tick("branch", F, 2'b11, PC_BR, RUN, 1'b0);
        tick("br_next", F, 2'b00, PC_SEQ, RUN, 1'b0);
        br_taken_ex_i = 1'b1;
        inst_d_i = mk_r(5'd5, 5'd1);
        lw_in_ex(5'd5);
        tick("br_over_lu", F, 2'b11, PC_BR, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        dready_i = 1'b1;
        tick("dhit", F, 2'b00, PC_SEQ, RUN, 1'b0);

        for (int i = 0; i < 5; i++) begin
            dreq_ex_i = 1'b1;
            tick("dmiss", 4'b0000, 2'b00, PC_SEQ,
                 (i == 0) ? RUN : MEM_WAIT, (i == 3));
        end
        dreq_ex_i = 1'b1;
        dready_i = 1'b1;
        tick("dmiss_rel", F, 2'b00, PC_SEQ, MEM_WAIT, 1'b0);
        tick("dmiss_run", F, 2'b00, PC_SEQ, RUN, 1'b0);

        dreq_ex_i = 1'b1;
        tick("lat_enter", 4'b0000, 2'b00, PC_SEQ, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        intr_flag_i = 1'b1;
        tick("lat_intr", 4'b0000, 2'b00, PC_SEQ, MEM_WAIT, 1'b0);
        dreq_ex_i = 1'b1;
        dready_i = 1'b1;
        br_taken_ex_i = 1'b1;
        tick("lat_apply", F, 2'b11, PC_INTR, MEM_WAIT, 1'b0);
        tick("lat_redir", F, 2'b11, PC_SEQ, REDIRECT, 1'b0);
        tick("lat_done", F, 2'b00, PC_SEQ, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        br_taken_ex_i = 1'b1;
        tick("latb_enter", 4'b0000, 2'b00, PC_SEQ, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        dready_i = 1'b1;
        tick("latb_apply", F, 2'b11, PC_BR, MEM_WAIT, 1'b0);
        tick("latb_done", F, 2'b00, PC_SEQ, RUN, 1'b0);

        ihit_i = 1'b0;
        tick("imiss", 4'b0111, 2'b10, PC_SEQ, RUN, 1'b0);
        ihit_i = 1'b0;
        tick("imiss_wait", 4'b0111, 2'b10, PC_SEQ, IMISS_WAIT, 1'b0);
        tick("imiss_hit", F, 2'b00, PC_SEQ, IMISS_WAIT, 1'b0);
        tick("imiss_run", F, 2'b00, PC_SEQ, RUN, 1'b0);
        ihit_i = 1'b0;
        inst_d_i = mk_r(5'd5, 5'd1);
        lw_in_ex(5'd5);
        tick("lu_over_imiss", 4'b0011, 2'b01, PC_SEQ, RUN, 1'b0);
        tick("lu_over_hold", F, 2'b00, PC_SEQ, LD_STALL, 1'b0);
        ihit_i = 1'b0;
        tick("imiss2", 4'b0111, 2'b10, PC_SEQ, RUN, 1'b0);
        ihit_i = 1'b0;
        br_taken_ex_i = 1'b1;
        tick("imiss_br", F, 2'b11, PC_BR, IMISS_WAIT, 1'b0);
        tick("imiss_br_run", F, 2'b00, PC_SEQ, RUN, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ihit_i = 1'b0;
            tick("imiss_to", 4'b0111, 2'b10, PC_SEQ,
                 (i == 0) ? RUN : IMISS_WAIT, (i == 3));
        end
        tick("imiss_to_hit", F, 2'b00, PC_SEQ, IMISS_WAIT, 1'b0);

        for (int i = 0; i < 6; i++) begin
            dreq_ex_i = 1'b1;
            tick("dmiss_to", 4'b0000, 2'b00, PC_SEQ,
                 (i == 0) ? RUN : MEM_WAIT, (i == 3));
        end
        rst_ni = 1'b0;
        dreq_ex_i = 1'b1;
        exp_cnt = 32'd0;
        tick("rst_mid", F, 2'b00, PC_SEQ, RUN, 1'b0);
        rst_ni = 1'b1;
        tick("post_rst", F, 2'b00, PC_SEQ, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        tick("post_miss", 4'b0000, 2'b00, PC_SEQ, RUN, 1'b0);
        dreq_ex_i = 1'b1;
        dready_i = 1'b1;
        tick("post_rel", F, 2'b00, PC_SEQ, MEM_WAIT, 1'b0);
        tick("post_run", F, 2'b00, PC_SEQ, RUN, 1'b0);

        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d left want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
